// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory responder
package mem_pkg;
   localparam int LATENCY_DEF    = 4;
   localparam int WORDS_LOG2_DEF = 10;
   localparam int CNT_W          = 4;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, GAP} state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: cache-to-memory request/response bus
interface mem_responder_if;
   logic        MEM_RE;
   logic        MEM_WE;
   logic [15:0] MEM_addr;
   logic [15:0] MEM_wdata;
   logic [15:0] MEM_rdata;
   logic        MEM_rdata_valid;
   logic        MEM_wdone;
   logic        busy;
   modport master (output MEM_RE, MEM_WE, MEM_addr, MEM_wdata,
                   input  MEM_rdata, MEM_rdata_valid, MEM_wdone, busy);
   modport slave  (input  MEM_RE, MEM_WE, MEM_addr, MEM_wdata,
                   output MEM_rdata, MEM_rdata_valid, MEM_wdone, busy);
endinterface

// File: rtl/mem_word_array.sv
// mem_word_array: 16-bit word storage, one sync write port, one comb read port
module mem_word_array #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [15:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [15:0]   rdata_o
);
   // contents start at zero and are deliberately untouched by reset
   logic [15:0] mem_q [2**AW] = '{default: '0};
   // synchronous write port
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory model answering cache read/write requests
module mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY    = LATENCY_DEF,
   parameter int WORDS_LOG2 = WORDS_LOG2_DEF
) (
   input logic             clk,
   input logic             rst_n,
   mem_responder_if.slave  bus
);
   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [WORDS_LOG2-1:0]   idx_q;
   logic [15:0]             wdata_q;
   logic [15:0]             rdata_q;
   logic                    rvalid_q;
   logic                    wdone_q;
   logic [15:0]             arr_rdata;
   logic                    arr_we;
   logic                    addr_unused;
   // the array is only written on the completing cycle, so a reset-aborted write leaves it intact
   assign arr_we      = (state_q == WR_WAIT) && (cnt_q == '0);
   assign addr_unused = ^bus.MEM_addr;
   mem_word_array #(.AW(WORDS_LOG2)) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .raddr_i (idx_q),
      .rdata_o (arr_rdata)
   );
   // request FSM: accept in IDLE (write wins), count down, pulse, one GAP cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         rdata_q  <= '0;
         case (state_q)
            IDLE:
               if (bus.MEM_WE || bus.MEM_RE) begin
                  idx_q   <= bus.MEM_addr[WORDS_LOG2:1];
                  wdata_q <= bus.MEM_wdata;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  state_q <= bus.MEM_WE ? WR_WAIT : RD_WAIT;
               end
            RD_WAIT, WR_WAIT:
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
               else begin
                  rvalid_q <= (state_q == RD_WAIT);
                  wdone_q  <= (state_q == WR_WAIT);
                  rdata_q  <= (state_q == RD_WAIT) ? arr_rdata : '0;
                  state_q  <= GAP;
               end
            default: state_q <= IDLE;
         endcase
      end
   assign bus.MEM_rdata       = rdata_q;
   assign bus.MEM_rdata_valid = rvalid_q;
   assign bus.MEM_wdone       = wdone_q;
   assign bus.busy            = (state_q != IDLE);
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to response pulse; legal range 1..15.
REQ-002 SHALL have parameter WORDS_LOG2, default 10: log2 of the number of 16-bit words stored.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port MEM_RE, input, 1: read request from cache; level, held until response.
REQ-006 SHALL have port MEM_WE, input, 1: write request from cache; level, held until response.
REQ-007 SHALL have port MEM_addr, input, 16: byte address; bit 0 ignored; word index = MEM_addr[WORDS_LOG2:1].
REQ-008 SHALL have port MEM_wdata, input, 16: write data.
REQ-009 SHALL have port MEM_rdata, output, 16: read data; meaningful only while MEM_rdata_valid.
REQ-010 SHALL have port MEM_rdata_valid, output, 1: one-cycle read-completion pulse.
REQ-011 SHALL have port MEM_wdone, output, 1: one-cycle write-completion pulse.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT and GAP.
REQ-014 In IDLE with MEM_WE=1, SHALL latch MEM_addr and MEM_wdata, load counter with LATENCY-1, and go to WR_WAIT.
REQ-015 In IDLE with MEM_RE=1 and MEM_WE=0, SHALL latch MEM_addr, load counter with LATENCY-1, and go to RD_WAIT.
REQ-016 When MEM_RE and MEM_WE are both high in IDLE, the write SHALL win; a still-held MEM_RE SHALL be accepted after GAP.
REQ-017 In RD_WAIT/WR_WAIT with counter nonzero, SHALL decrement the counter by 1.
REQ-018 In RD_WAIT with counter=0, SHALL drive MEM_rdata=array[latched index], pulse MEM_rdata_valid for exactly 1 cycle, and go to GAP.
REQ-019 In WR_WAIT with counter=0, SHALL write latched data to array[latched index], pulse MEM_wdone for exactly 1 cycle, and go to GAP.
REQ-020 Request acceptance to pulse SHALL take exactly LATENCY cycles; with LATENCY=1 the pulse is the cycle after acceptance.
REQ-021 GAP SHALL last 1 cycle, ignore requests, and return to IDLE; minimum spacing between accepted requests is LATENCY+2 cycles.
REQ-022 Changes on MEM_addr, MEM_wdata, MEM_RE or MEM_WE after acceptance SHALL NOT alter the in-flight operation; a request deasserted mid-operation still completes and pulses.
REQ-023 Address bits above WORDS_LOG2 SHALL be ignored (aliasing wrap-around); 16'hFFFE and 16'h07FE map to the same word when WORDS_LOG2=10.
REQ-024 MEM_rdata SHALL read 16'h0000 whenever MEM_rdata_valid is low.
REQ-025 MEM_rdata_valid and MEM_wdone SHALL never be high in the same cycle.

Reset
REQ-026 While rst_n=0: state=IDLE, counter=0, MEM_rdata_valid=0, MEM_wdone=0, MEM_rdata=16'h0000, busy=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no pulse; an aborted write SHALL NOT modify the array.
REQ-028 Array contents SHALL be zero-initialised at simulation start and SHALL NOT be cleared by rst_n.

Structure
REQ-029 Package mem_pkg SHALL hold the state enum, the LATENCY/WORDS_LOG2 defaults and the counter width (4).
REQ-030 Storage SHALL be a sub-module mem_word_array with one synchronous write port and one combinational read port; the FSM and counter SHALL stay in mem_responder.

Verification
REQ-031 Write 16'hBEEF at addr 16'h0010, then read 16'h0010 -> MEM_wdone pulses 4 cycles after acceptance; later MEM_rdata_valid pulses with MEM_rdata=16'hBEEF.
REQ-032 Hold MEM_RE for 8 sequential fill reads at 16'h0020..16'h002E, changing addr after each valid -> 8 valid pulses spaced 6 cycles apart, data as preloaded.
REQ-033 Assert MEM_RE and MEM_WE together (addr 16'h0040, data 16'h1234) -> wdone first, then GAP, then read returns 16'h1234.
REQ-034 Assert rst_n=0 two cycles into a write of 16'hAAAA at 16'h0050, then read 16'h0050 -> no wdone during the aborted write; read returns the prior value 16'h0000.
REQ-035 Write 16'h5555 at 16'h07FE, then read 16'hFFFE with WORDS_LOG2=10 -> read returns 16'h5555.
REQ-036 Drop MEM_RE one cycle after acceptance -> MEM_rdata_valid still pulses exactly LATENCY cycles after acceptance; busy returns low after GAP.
